// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path and the matching transmitter.
// Holds the bit-level FSM states, the line-assembly states, the newline
// terminator and the default bit period (100 MHz / 9600 baud).
package uart_pkg;

    localparam int         DEFAULT_CLKS_PER_BIT = 10417;
    localparam logic [7:0] NEWLINE              = 8'h0A;

    // Bit-level receiver states.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Line assembly states: collecting characters, presenting a finished
    // line to the consumer, or dropping an over-long line until its '\n'.
    typedef enum logic [1:0] {
        LINE_COLLECT,
        LINE_PRESENT,
        LINE_DISCARD
    } line_state_t;

endpackage

// File: rtl/uart_message_receiver_if.sv
// Consumer-facing bundle of the message receiver.
//   word / word_valid        : last received byte and its one-cycle strobe
//   message / message_len    : presented line (first char in the MSB byte)
//   message_valid            : high while a complete line is presented
//   message_ack              : consumer has taken the presented line
// master = receiver side, slave = consumer side.
interface uart_message_receiver_if #(
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]           word;
    logic                 word_valid;
    logic [8*MAX_LEN-1:0] message;
    logic [LEN_W-1:0]     message_len;
    logic                 message_valid;
    logic                 message_ack;

    modport master (
        output word, word_valid, message, message_len, message_valid,
        input  message_ack
    );

    modport slave (
        input  word, word_valid, message, message_len, message_valid,
        output message_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver: 2-flop input synchroniser, bit FSM and baud counter.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   rxd          : asynchronous serial input, idle high
//   word         : last correctly framed byte
//   word_valid   : one-cycle pulse when word updates
//   frame_error  : sticky, set when a stop bit is sampled low
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] word,
    output logic       word_valid,
    output logic       frame_error
);
    localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rxd_meta, rxd_sync;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             stop_wait, stop_wait_nxt;   // bad stop bit seen, waiting for line idle
    logic [7:0]       word_nxt;
    logic             word_valid_nxt, frame_error_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            stop_wait   <= 1'b0;
            word        <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rxd_meta    <= rxd;
            rxd_sync    <= rxd_meta;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            stop_wait   <= stop_wait_nxt;
            word        <= word_nxt;
            word_valid  <= word_valid_nxt;
            frame_error <= frame_error_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        bit_idx_nxt     = bit_idx;
        shift_nxt       = shift;
        stop_wait_nxt   = stop_wait;
        word_nxt        = word;
        word_valid_nxt  = 1'b0;
        frame_error_nxt = frame_error;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxd_sync) state_nxt = START;
            end
            START: begin
                // Re-check in the middle of the start bit to reject glitches.
                if (cnt == CNT_HALF) begin
                    if (!rxd_sync) begin
                        state_nxt   = DATA;
                        cnt_nxt     = '0;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_nxt   = {rxd_sync, shift[7:1]};   // LSB first
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (stop_wait) begin
                    if (rxd_sync) begin
                        stop_wait_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    if (rxd_sync) begin
                        word_nxt       = shift;
                        word_valid_nxt = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        frame_error_nxt = 1'b1;
                        stop_wait_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_message_receiver.sv
// UART line receiver: turns received bytes into '\n'-terminated lines and
// presents each line to the consumer with a valid/ack handshake.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   rxd          : asynchronous serial input, idle high
//   msg          : consumer bundle (word strobe, line buffer, length, valid/ack)
//   frame_error  : sticky, a stop bit was sampled low
//   overflow     : sticky, line longer than MAX_LEN or byte during presentation
module uart_message_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_LEN      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rxd,
    uart_message_receiver_if.master        msg,
    output logic                           frame_error,
    output logic                           overflow
);
    localparam int               LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] PTR_LAST = LEN_W'(MAX_LEN - 1);

    logic [7:0]           rx_word;
    logic                 rx_valid;
    line_state_t          line_state, line_state_nxt;
    logic [8*MAX_LEN-1:0] line_buf, line_buf_nxt;
    logic [LEN_W-1:0]     wr_ptr, wr_ptr_nxt;
    logic [LEN_W-1:0]     len, len_nxt;
    logic                 overflow_nxt;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .word        (rx_word),
        .word_valid  (rx_valid),
        .frame_error (frame_error)
    );

    // NOTE: the line buffer is reset because it is a visible output that must
    // read as all zeros out of reset, not just a storage array.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_state <= LINE_COLLECT;
            line_buf   <= '0;
            wr_ptr     <= '0;
            len        <= '0;
            overflow   <= 1'b0;
        end else begin
            line_state <= line_state_nxt;
            line_buf   <= line_buf_nxt;
            wr_ptr     <= wr_ptr_nxt;
            len        <= len_nxt;
            overflow   <= overflow_nxt;
        end
    end

    always_comb begin
        line_state_nxt = line_state;
        line_buf_nxt   = line_buf;
        wr_ptr_nxt     = wr_ptr;
        len_nxt        = len;
        overflow_nxt   = overflow;

        case (line_state)
            LINE_COLLECT: begin
                if (rx_valid) begin
                    if (rx_word == NEWLINE) begin
                        line_buf_nxt[8*(MAX_LEN-1-int'(wr_ptr)) +: 8] = rx_word;
                        len_nxt        = wr_ptr + 1'b1;
                        wr_ptr_nxt     = '0;
                        line_state_nxt = LINE_PRESENT;
                    end else if (wr_ptr == PTR_LAST) begin
                        // No room left for the terminator: drop the whole line.
                        overflow_nxt   = 1'b1;
                        line_state_nxt = LINE_DISCARD;
                    end else begin
                        line_buf_nxt[8*(MAX_LEN-1-int'(wr_ptr)) +: 8] = rx_word;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                end
            end
            LINE_PRESENT: begin
                // Bytes cannot be stored while the line is held; an ack in the
                // same cycle still wins and the byte is lost.
                if (rx_valid) overflow_nxt = 1'b1;
                if (msg.message_ack) begin
                    line_buf_nxt   = '0;
                    len_nxt        = '0;
                    line_state_nxt = LINE_COLLECT;
                end
            end
            LINE_DISCARD: begin
                if (rx_valid && rx_word == NEWLINE) begin
                    line_buf_nxt   = '0;
                    wr_ptr_nxt     = '0;
                    line_state_nxt = LINE_COLLECT;
                end
            end
            default: line_state_nxt = LINE_COLLECT;
        endcase
    end

    assign msg.word          = rx_word;
    assign msg.word_valid    = rx_valid;
    assign msg.message       = line_buf;
    assign msg.message_len   = len;
    assign msg.message_valid = (line_state == LINE_PRESENT);

endmodule

// File: tb/tb_uart_message_receiver.sv
// Scoreboard bench for uart_message_receiver at CLKS_PER_BIT=16, MAX_LEN=16.
// Stimulus pushes expected bytes/lines into queues; a negedge monitor pops and
// compares whenever the DUT strobes word_valid or raises message_valid.
module tb_uart_message_receiver;
    import uart_pkg::*;

    localparam int CPB     = 16;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef logic [8*MAX_LEN-1:0] msg_t;
    typedef struct {
        msg_t             data;
        logic [LEN_W-1:0] len;
    } exp_msg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic frame_error, overflow;

    uart_message_receiver_if #(.MAX_LEN(MAX_LEN)) msg_if ();

    uart_message_receiver #(
        .CLKS_PER_BIT (CPB),
        .MAX_LEN      (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .msg         (msg_if),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] word_q[$];
    exp_msg_t   msg_q[$];

    task automatic check(input string name, input msg_t act, input msg_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic msg_t pack_msg(input string s);
        msg_t m = '0;
        for (int i = 0; i < s.len(); i++) m[8*(MAX_LEN-1-i) +: 8] = s[i];
        return m;
    endfunction

    task automatic expect_line(input string s, input bit present);
        exp_msg_t e;
        for (int i = 0; i < s.len(); i++) word_q.push_back(s[i]);
        if (present) begin
            e.data = pack_msg(s);
            e.len  = LEN_W'(s.len());
            msg_q.push_back(e);
        end
    endtask

    // Drives one 8N1 frame starting on a negedge; stop_bit=0 forces a framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!msg_if.message_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("message_valid_wait", msg_t'(msg_if.message_valid), msg_t'(1));
    endtask

    task automatic do_ack();
        @(negedge clk);
        msg_if.message_ack = 1'b1;
        @(negedge clk);
        msg_if.message_ack = 1'b0;
        check("ack_valid_low", msg_t'(msg_if.message_valid), '0);
        check("ack_message_zero", msg_if.message, '0);
        check("ack_len_zero", msg_t'(msg_if.message_len), '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, msg_t'(msg_if.word), '0);
        check({tag, "_word_valid"}, msg_t'(msg_if.word_valid), '0);
        check({tag, "_message"}, msg_if.message, '0);
        check({tag, "_message_len"}, msg_t'(msg_if.message_len), '0);
        check({tag, "_message_valid"}, msg_t'(msg_if.message_valid), '0);
        check({tag, "_frame_error"}, msg_t'(frame_error), '0);
        check({tag, "_overflow"}, msg_t'(overflow), '0);
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    logic       mv_d = 1'b0;
    logic [7:0] mon_word;
    exp_msg_t   mon_msg;

    always @(negedge clk) begin
        if (rst) begin
            mv_d <= 1'b0;
        end else begin
            if (msg_if.word_valid) begin
                if (word_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected no byte", msg_if.word);
                end else begin
                    mon_word = word_q.pop_front();
                    check("word", msg_t'(msg_if.word), msg_t'(mon_word));
                end
            end
            if (msg_if.message_valid && !mv_d) begin
                if (msg_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_message: got %h expected no line", msg_if.message);
                end else begin
                    mon_msg = msg_q.pop_front();
                    check("message", msg_if.message, mon_msg.data);
                    check("message_len", msg_t'(msg_if.message_len), msg_t'(mon_msg.len));
                end
            end
            mv_d <= msg_if.message_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        msg_t         exp_m;
        logic [7:0]   partial;
        exp_msg_t     e;

        msg_if.message_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Full greeting line, then hold it un-acked for 100 cycles.
        expect_line("Hello world!\n", 1'b1);
        send_str("Hello world!\n");
        wait_valid(200);
        exp_m = pack_msg("Hello world!\n");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("hold_message", msg_if.message, exp_m);
            check("hold_valid", msg_t'(msg_if.message_valid), msg_t'(1));
        end
        do_ack();

        // One-cycle low glitch while idle: no byte, no flags.
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_frame_error", msg_t'(frame_error), '0);
        check("glitch_overflow", msg_t'(overflow), '0);

        // Bad stop bit on 8'h55, then a good 8'hA5 and a newline.
        send_byte(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        check("frame_error_set", msg_t'(frame_error), msg_t'(1));
        word_q.push_back(8'hA5);
        word_q.push_back(NEWLINE);
        e.data = '0;
        e.data[8*MAX_LEN-1 -: 8] = 8'hA5;
        e.data[8*MAX_LEN-9 -: 8] = NEWLINE;
        e.len  = LEN_W'(2);
        msg_q.push_back(e);
        send_byte(8'hA5, 1'b1);
        send_byte(NEWLINE, 1'b1);
        wait_valid(200);

        // A byte while the line is presented: strobed but dropped, overflow set.
        word_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        check("busy_overflow", msg_t'(overflow), msg_t'(1));
        check("busy_valid", msg_t'(msg_if.message_valid), msg_t'(1));
        check("busy_message", msg_if.message, e.data);
        check("busy_len", msg_t'(msg_if.message_len), msg_t'(2));
        do_ack();

        // Reset during data bit 4 of a frame: everything clears.
        partial = NEWLINE;
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = partial[4];
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_frame_reset");
        rst = 1'b0;
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        expect_line("\n", 1'b1);
        send_byte(NEWLINE, 1'b1);
        wait_valid(200);
        do_ack();

        // Over-long line: 20 'A' then '\n' is discarded.
        for (int i = 0; i < 20; i++) word_q.push_back(8'h41);
        word_q.push_back(NEWLINE);
        for (int i = 0; i < 20; i++) send_byte(8'h41, 1'b1);
        send_byte(NEWLINE, 1'b1);
        repeat (20) @(negedge clk);
        check("long_overflow", msg_t'(overflow), msg_t'(1));
        check("long_no_valid", msg_t'(msg_if.message_valid), '0);

        expect_line("Hi\n", 1'b1);
        send_str("Hi\n");
        wait_valid(200);
        do_ack();

        repeat (20) @(negedge clk);
        check("word_queue_drained", msg_t'(word_q.size()), '0);
        check("msg_queue_drained", msg_t'(msg_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
